// File: rtl/jk_counter_reg.sv
// Bank of WIDTH JK flip-flops with per-bit JK, parallel load and up/down counting via the JK toggle chain.
// Optional build macro JK_COUNT_SAT_EN: when defined, UP saturates at all-ones and DOWN saturates at zero.
module jk_counter_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_up_tgl;
    logic [WIDTH-1:0] w_dn_tgl;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_all_ones;
    logic             w_all_zero;
    mode_t            w_mode;

    assign w_mode     = mode_t'(mode);
    assign w_all_ones = &r_q;
    assign w_all_zero = ~|r_q;

    // Toggle chains: bit i toggles when all lower bits are 1 (up) or all 0 (down)
    always_comb begin
        w_up_tgl    = '0;
        w_dn_tgl    = '0;
        w_up_tgl[0] = 1'b1;
        w_dn_tgl[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_tgl[i] = w_up_tgl[i-1] & r_q[i-1];
            w_dn_tgl[i] = w_dn_tgl[i-1] & ~r_q[i-1];
        end
    end

    // Per-mode J/K drive for every flip-flop of the bank
    always_comb begin
        w_j = '0;
        w_k = '0;
        case (w_mode)
            MODE_JK: begin
                w_j = j;
                w_k = k;
            end
            MODE_LOAD: begin
                w_j = d;
                w_k = ~d;
            end
            MODE_UP: begin
`ifdef JK_COUNT_SAT_EN
                if (w_all_ones) begin
                    w_j = '0;
                    w_k = '0;
                end else begin
                    w_j = w_up_tgl;
                    w_k = w_up_tgl;
                end
`else
                w_j = w_up_tgl;
                w_k = w_up_tgl;
`endif
            end
            MODE_DOWN: begin
`ifdef JK_COUNT_SAT_EN
                if (w_all_zero) begin
                    w_j = '0;
                    w_k = '0;
                end else begin
                    w_j = w_dn_tgl;
                    w_k = w_dn_tgl;
                end
`else
                w_j = w_dn_tgl;
                w_k = w_dn_tgl;
`endif
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // JK characteristic equation Q+ = J&~Q | ~K&Q, gated by the update enable
    always_comb begin
        w_q_nxt = r_q;
        if (en) begin
            w_q_nxt = (w_j & ~r_q) | (~w_k & r_q);
        end else begin
            w_q_nxt = r_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_nxt;
        end
    end

    // Terminal count only flags the count boundary in the enabled counting modes
    always_comb begin
        tc = 1'b0;
        if (en && (w_mode == MODE_UP)) begin
            tc = w_all_ones;
        end else if (en && (w_mode == MODE_DOWN)) begin
            tc = w_all_zero;
        end else begin
            tc = 1'b0;
        end
    end

    assign q    = r_q;
    assign qbar = ~r_q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Self-checking bench for jk_counter_reg: directed scenarios plus randomized stimulus against an arithmetic reference model.
module tb_jk_counter_reg;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst2;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       tc;
    logic [7:0] q2;
    logic [7:0] qbar2;
    logic       tc2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q;

    always #5 clk = ~clk;

    jk_counter_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .q(q), .qbar(qbar), .tc(tc)
    );

    jk_counter_reg #(.WIDTH(8), .RESET_VAL(8'h80)) dut_rv (
        .clk(clk), .reset(rst2), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .q(q2), .qbar(qbar2), .tc(tc2)
    );

    // Reference model: next value from the behavioural rules using plain arithmetic
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic e,
                                              input logic [1:0] m, input logic [7:0] jj,
                                              input logic [7:0] kk, input logic [7:0] dd);
        logic [7:0] r;
        int         v;
        r = cur;
        if (e) begin
            if (m == 2'd0) begin
                for (int i = 0; i < 8; i++) begin
                    if (jj[i] && kk[i])       r[i] = ~cur[i];
                    else if (jj[i])           r[i] = 1'b1;
                    else if (kk[i])           r[i] = 1'b0;
                    else                      r[i] = cur[i];
                end
            end else if (m == 2'd1) begin
                r = dd;
            end else if (m == 2'd2) begin
                v = (int'(cur) + 1) % 256;
`ifdef JK_COUNT_SAT_EN
                if (cur == 8'd255) v = 255;
`endif
                r = v[7:0];
            end else begin
                v = (int'(cur) + 255) % 256;
`ifdef JK_COUNT_SAT_EN
                if (cur == 8'd0) v = 0;
`endif
                r = v[7:0];
            end
        end
        return r;
    endfunction

    function automatic logic model_tc(input logic [7:0] cur, input logic e, input logic [1:0] m);
        return e && (((m == 2'd2) && (cur == 8'd255)) || ((m == 2'd3) && (cur == 8'd0)));
    endfunction

    task automatic step();
        logic [7:0] nx;
        nx = model_next(exp_q, en, mode, j, k, d);
        @(posedge clk);
        #1;
        exp_q = nx;
    endtask

    task automatic test_reset();
        reset = 1'b0; rst2 = 1'b0; en = 1'b0; mode = 2'd0;
        j = 8'h00; k = 8'h00; d = 8'h00; exp_q = 8'h00;
        #2;
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || tc !== 1'b0) begin
            errors++; $display("FAIL reset_init: q=%h qbar=%h tc=%b, want 00 FF 0", q, qbar, tc);
        end
        @(posedge clk); #1;
        reset = 1'b1; rst2 = 1'b1;
        en = 1'b1; mode = 2'd1; d = 8'h5A;
        step();
        checks++;
        if (q !== 8'h5A) begin errors++; $display("FAIL reset_preload: q=%h want 5a", q); end
        #2 reset = 1'b0;
        #1;
        exp_q = 8'h00;
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF) begin
            errors++; $display("FAIL reset_async: q=%h qbar=%h want 00 FF", q, qbar);
        end
        reset = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q !== 8'h00) begin errors++; $display("FAIL reset_hold: q=%h want 00", q); end
    endtask

    task automatic test_jk();
        en = 1'b1; mode = 2'd1; d = 8'h0F; step();
        mode = 2'd0; j = 8'hF0; k = 8'h3C; step();
        checks++;
        if (q !== 8'hF3 || qbar !== 8'h0C || tc !== 1'b0) begin
            errors++; $display("FAIL jk_mixed: q=%h qbar=%h tc=%b want F3 0C 0", q, qbar, tc);
        end
    endtask

    task automatic test_load_toggle();
        en = 1'b1; mode = 2'd1; d = 8'hA5; j = 8'h00; k = 8'hFF; step();
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL load: q=%h want A5", q); end
        mode = 2'd0; j = 8'hFF; k = 8'hFF; step();
        checks++;
        if (q !== 8'h5A) begin errors++; $display("FAIL jk_toggle: q=%h want 5A", q); end
    endtask

    task automatic test_up_wrap();
        en = 1'b1; mode = 2'd1; d = 8'hFE; step();
        mode = 2'd2; step();
        checks++;
        if (q !== 8'hFF || tc !== 1'b1) begin
            errors++; $display("FAIL up_edge1: q=%h tc=%b want FF 1", q, tc);
        end
        step();
        checks++;
`ifdef JK_COUNT_SAT_EN
        if (q !== 8'hFF || tc !== 1'b1) begin
            errors++; $display("FAIL up_sat: q=%h tc=%b want FF 1", q, tc);
        end
`else
        if (q !== 8'h00 || tc !== 1'b0) begin
            errors++; $display("FAIL up_wrap: q=%h tc=%b want 00 0", q, tc);
        end
`endif
    endtask

    task automatic test_down_wrap();
        en = 1'b1; mode = 2'd1; d = 8'h01; step();
        mode = 2'd3; step();
        checks++;
        if (q !== 8'h00 || tc !== 1'b1) begin
            errors++; $display("FAIL down_edge1: q=%h tc=%b want 00 1", q, tc);
        end
        step();
        checks++;
`ifdef JK_COUNT_SAT_EN
        if (q !== 8'h00 || tc !== 1'b1) begin
            errors++; $display("FAIL down_sat: q=%h tc=%b want 00 1", q, tc);
        end
`else
        if (q !== 8'hFF || tc !== 1'b0) begin
            errors++; $display("FAIL down_wrap: q=%h tc=%b want FF 0", q, tc);
        end
`endif
    endtask

    task automatic test_hold_glitch();
        logic [7:0] held;
        held = exp_q;
        en = 1'b0; mode = 2'd2;
        checks++;
        if (tc !== 1'b0) begin errors++; $display("FAIL tc_disabled: tc=%b want 0", tc); end
        #2 en = 1'b1; mode = 2'd1; d = 8'h33;
        #2 en = 1'b0;
        step();
        checks++;
        if (q !== held) begin errors++; $display("FAIL hold_glitch: q=%h want %h", q, held); end
    endtask

    task automatic test_random();
        logic [7:0] picks [4];
        picks[0] = 8'h00; picks[1] = 8'hFF; picks[2] = 8'hFE; picks[3] = 8'h01;
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            j    = 8'($urandom());
            k    = 8'($urandom());
            d    = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 3)] : 8'($urandom());
            step();
            checks++;
            if (q !== exp_q || qbar !== ~exp_q) begin
                errors++; $display("FAIL random_q[%0d]: q=%h qbar=%h want %h", n, q, qbar, exp_q);
            end
            checks++;
            if (tc !== model_tc(exp_q, en, mode)) begin
                errors++; $display("FAIL random_tc[%0d]: tc=%b want %b (q=%h en=%b mode=%0d)",
                                   n, tc, model_tc(exp_q, en, mode), exp_q, en, mode);
            end
        end
    endtask

    task automatic test_reset_val();
        rst2 = 1'b0; #1;
        checks++;
        if (q2 !== 8'h80 || qbar2 !== 8'h7F) begin
            errors++; $display("FAIL rv_reset: q=%h qbar=%h want 80 7F", q2, qbar2);
        end
        rst2 = 1'b1; en = 1'b1; mode = 2'd2;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (q2 !== 8'h85) begin errors++; $display("FAIL rv_count: q=%h want 85", q2); end
        #2 rst2 = 1'b0;
        #1;
        checks++;
        if (q2 !== 8'h80 || tc2 !== 1'b0) begin
            errors++; $display("FAIL rv_abort: q=%h tc=%b want 80 0", q2, tc2);
        end
        rst2 = 1'b1;
        step();
        checks++;
        if (q2 !== 8'h81) begin errors++; $display("FAIL rv_release: q=%h want 81", q2); end
    endtask

    initial begin
        test_reset();
        test_jk();
        test_load_toggle();
        test_up_wrap();
        test_down_wrap();
        test_hold_glitch();
        test_random();
        test_reset_val();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
